// File: rtl/decoder_leaf_n.sv
// Routes flits from one input to one of N buffered outputs, steered by a separate select channel.
// In packet mode the select is taken on the head flit only and the route is held until the tail.
module decoder_leaf_n #(
  parameter int unsigned W        = 9,
  parameter int unsigned N        = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PKT_MODE = 0,
  localparam int unsigned SW      = $clog2(N)
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SW-1:0]  s_data,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic           err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [SW:0] NMAX = (SW + 1)'(N);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] route_q, route_d;
  logic          err_q, err_d;
  logic [N-1:0]  full;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic          sel_full;
  logic          route_full;
  logic          in_range;

  assign in_range = ({1'b0, s_data} < NMAX);
  assign err      = err_q;

  // Loop lookups keep an out-of-range select from ever indexing past the FIFO array.
  always_comb begin
    sel_full   = 1'b0;
    route_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (s_data == SW'(k)) sel_full = full[k];
      if (route_q == SW'(k)) route_full = full[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    err_d    = err_q;
    push     = '0;
    in_ready = 1'b0;
    s_ready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_range) begin
          in_ready = s_valid & ~sel_full;
          s_ready  = in_valid & ~sel_full;
          if (in_valid && s_valid && !sel_full) begin
            for (int k = 0; k < N; k++) begin
              if (s_data == SW'(k)) push[k] = 1'b1;
            end
            if ((PKT_MODE != 0) && !in_data[W-1]) begin
              state_d = StLocked;
              route_d = s_data;
            end
          end
        end else begin
          // Unroutable select: swallow both tokens so the channel does not wedge.
          in_ready = in_valid & s_valid;
          s_ready  = in_valid & s_valid;
          if (in_valid && s_valid) err_d = 1'b1;
        end
      end
      StLocked: begin
        in_ready = ~route_full;
        if (in_valid && !route_full) begin
          for (int k = 0; k < N; k++) begin
            if (route_q == SW'(k)) push[k] = 1'b1;
          end
          if (in_data[W-1]) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!_RESET) begin
      in_ready = 1'b0;
      s_ready  = 1'b0;
      push     = '0;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= StIdle;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_fifo
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    assign full[k]              = (cnt_q == CW'(DEPTH));
    assign out_valid[k]         = (cnt_q != '0);
    assign pop[k]               = out_valid[k] & out_ready[k];
    assign out_data[k*W +: W]   = mem_q[rptr_q];

    always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[k]) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop[k])  rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        if (push[k] && !pop[k])      cnt_q <= cnt_q + 1'b1;
        else if (!push[k] && pop[k]) cnt_q <= cnt_q - 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (push[k]) mem_q[wptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_decoder_leaf_n.sv
// Directed bench for decoder_leaf_n: per-flit routing, backpressure, packet lock, range error, reset.
module tb_decoder_leaf_n;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // a: N=4 per-flit mode; b: N=4 packet mode; c: N=3 per-flit mode
  logic [8:0]  a_in_data, b_in_data, c_in_data;
  logic        a_in_valid, b_in_valid, c_in_valid;
  logic        a_in_ready, b_in_ready, c_in_ready;
  logic [1:0]  a_s_data, b_s_data, c_s_data;
  logic        a_s_valid, b_s_valid, c_s_valid;
  logic        a_s_ready, b_s_ready, c_s_ready;
  logic [35:0] a_out_data, b_out_data;
  logic [26:0] c_out_data;
  logic [3:0]  a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic [2:0]  c_out_valid, c_out_ready;
  logic        a_err, b_err, c_err;

  decoder_leaf_n #(.W(9), .N(4), .DEPTH(2), .PKT_MODE(0)) u_a (
    .CLK(CLK), ._RESET(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .err(a_err)
  );

  decoder_leaf_n #(.W(9), .N(4), .DEPTH(2), .PKT_MODE(1)) u_b (
    .CLK(CLK), ._RESET(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .err(b_err)
  );

  decoder_leaf_n #(.W(9), .N(3), .DEPTH(2), .PKT_MODE(0)) u_c (
    .CLK(CLK), ._RESET(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .s_data(c_s_data), .s_valid(c_s_valid), .s_ready(c_s_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .err(c_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    a_in_data = 9'h1FF; a_in_valid = 1'b1; a_s_data = 2'd1; a_s_valid = 1'b1; a_out_ready = '1;
    b_in_data = 9'h000; b_in_valid = 1'b0; b_s_data = 2'd0; b_s_valid = 1'b0; b_out_ready = '1;
    c_in_data = 9'h000; c_in_valid = 1'b0; c_s_data = 2'd0; c_s_valid = 1'b0; c_out_ready = '1;
    rst_n = 1'b0;
    step();
    step();
    total++; if (a_out_valid !== 4'b0000) begin bad++; $display("FAIL rst_out_valid got=%b exp=0000", a_out_valid); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", a_in_ready); end
    total++; if (a_s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", a_s_ready); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", a_err); end
    a_in_valid = 1'b0; a_s_valid = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    step();
    total++; if (b_out_valid !== 4'b0000) begin bad++; $display("FAIL rst_b_out_valid got=%b exp=0000", b_out_valid); end
  endtask

  task automatic test_route();
    a_out_ready = 4'b1111;
    a_in_data = 9'h101; a_s_data = 2'd2; a_in_valid = 1'b1; a_s_valid = 1'b1;
    #1;
    total++; if ({a_in_ready, a_s_ready} !== 2'b11) begin bad++; $display("FAIL route_join got=%b exp=11", {a_in_ready, a_s_ready}); end
    step();
    a_in_data = 9'h0A5; a_s_data = 2'd0;
    total++; if (a_out_valid !== 4'b0100) begin bad++; $display("FAIL route_v2 got=%b exp=0100", a_out_valid); end
    total++; if (a_out_data[18 +: 9] !== 9'h101) begin bad++; $display("FAIL route_d2 got=%h exp=101", a_out_data[18 +: 9]); end
    step();
    a_in_data = 9'h1FF; a_s_data = 2'd3;
    total++; if (a_out_valid !== 4'b0001) begin bad++; $display("FAIL route_v0 got=%b exp=0001", a_out_valid); end
    total++; if (a_out_data[0 +: 9] !== 9'h0A5) begin bad++; $display("FAIL route_d0 got=%h exp=0a5", a_out_data[0 +: 9]); end
    step();
    a_in_valid = 1'b0; a_s_valid = 1'b0;
    total++; if (a_out_valid !== 4'b1000) begin bad++; $display("FAIL route_v3 got=%b exp=1000", a_out_valid); end
    total++; if (a_out_data[27 +: 9] !== 9'h1FF) begin bad++; $display("FAIL route_d3 got=%h exp=1ff", a_out_data[27 +: 9]); end
    step();
    total++; if (a_out_valid !== 4'b0000) begin bad++; $display("FAIL route_drain got=%b exp=0000", a_out_valid); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 4'b1101;
    a_in_data = 9'h011; a_s_data = 2'd1; a_in_valid = 1'b1; a_s_valid = 1'b1;
    step();
    a_in_data = 9'h012;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready got=%b exp=1", a_in_ready); end
    step();
    a_in_data = 9'h013;
    #1;
    total++; if ({a_in_ready, a_s_ready} !== 2'b00) begin bad++; $display("FAIL bp_full_stall got=%b exp=00", {a_in_ready, a_s_ready}); end
    total++; if (a_out_data[9 +: 9] !== 9'h011) begin bad++; $display("FAIL bp_head got=%h exp=011", a_out_data[9 +: 9]); end
    step();
    step();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b exp=0", a_in_ready); end
    total++; if (a_out_valid !== 4'b0010) begin bad++; $display("FAIL bp_valid got=%b exp=0010", a_out_valid); end
    a_out_ready = 4'b1111;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_bypass got=%b exp=0", a_in_ready); end
    step();
    total++; if (a_out_data[9 +: 9] !== 9'h012) begin bad++; $display("FAIL bp_drain2 got=%h exp=012", a_out_data[9 +: 9]); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b exp=1", a_in_ready); end
    step();
    a_in_data = 9'h020; a_s_data = 2'd0;
    total++; if (a_out_data[9 +: 9] !== 9'h013 || a_out_valid !== 4'b0010) begin
      bad++; $display("FAIL bp_drain3 got=%h/%b exp=013/0010", a_out_data[9 +: 9], a_out_valid);
    end
    step();
    a_in_valid = 1'b0; a_s_valid = 1'b0;
    total++; if (a_out_valid !== 4'b0001 || a_out_data[0 +: 9] !== 9'h020) begin
      bad++; $display("FAIL bp_after got=%b/%h exp=0001/020", a_out_valid, a_out_data[0 +: 9]);
    end
    step();
    total++; if (a_out_valid !== 4'b0000) begin bad++; $display("FAIL bp_empty got=%b exp=0000", a_out_valid); end
  endtask

  task automatic test_packet();
    b_out_ready = 4'b1111;
    b_in_data = 9'h023; b_s_data = 2'd3; b_in_valid = 1'b1; b_s_valid = 1'b1;
    #1;
    total++; if ({b_in_ready, b_s_ready} !== 2'b11) begin bad++; $display("FAIL pkt_head got=%b exp=11", {b_in_ready, b_s_ready}); end
    step();
    b_in_data = 9'h055; b_s_data = 2'd1;
    #1;
    total++; if ({b_in_ready, b_s_ready} !== 2'b10) begin bad++; $display("FAIL pkt_body_hs got=%b exp=10", {b_in_ready, b_s_ready}); end
    total++; if (b_out_valid !== 4'b1000 || b_out_data[27 +: 9] !== 9'h023) begin
      bad++; $display("FAIL pkt_head_out got=%b/%h exp=1000/023", b_out_valid, b_out_data[27 +: 9]);
    end
    step();
    b_in_data = 9'h1AA;
    #1;
    total++; if (b_s_ready !== 1'b0) begin bad++; $display("FAIL pkt_tail_s got=%b exp=0", b_s_ready); end
    total++; if (b_out_valid !== 4'b1000 || b_out_data[27 +: 9] !== 9'h055) begin
      bad++; $display("FAIL pkt_body_out got=%b/%h exp=1000/055", b_out_valid, b_out_data[27 +: 9]);
    end
    step();
    b_in_data = 9'h1BB;
    #1;
    total++; if (b_s_ready !== 1'b1) begin bad++; $display("FAIL pkt_unlock got=%b exp=1", b_s_ready); end
    total++; if (b_out_valid !== 4'b1000 || b_out_data[27 +: 9] !== 9'h1AA) begin
      bad++; $display("FAIL pkt_tail_out got=%b/%h exp=1000/1aa", b_out_valid, b_out_data[27 +: 9]);
    end
    step();
    b_in_valid = 1'b0; b_s_valid = 1'b0;
    total++; if (b_out_valid !== 4'b0010 || b_out_data[9 +: 9] !== 9'h1BB) begin
      bad++; $display("FAIL pkt_next got=%b/%h exp=0010/1bb", b_out_valid, b_out_data[9 +: 9]);
    end
    step();
  endtask

  task automatic test_single_flit();
    b_in_data = 9'h1C3; b_s_data = 2'd2; b_in_valid = 1'b1; b_s_valid = 1'b1;
    step();
    b_in_data = 9'h144; b_s_data = 2'd0;
    #1;
    total++; if (b_s_ready !== 1'b1) begin bad++; $display("FAIL sf_idle got=%b exp=1", b_s_ready); end
    total++; if (b_out_valid !== 4'b0100 || b_out_data[18 +: 9] !== 9'h1C3) begin
      bad++; $display("FAIL sf_out got=%b/%h exp=0100/1c3", b_out_valid, b_out_data[18 +: 9]);
    end
    step();
    b_in_valid = 1'b0; b_s_valid = 1'b0;
    total++; if (b_out_valid !== 4'b0001 || b_out_data[0 +: 9] !== 9'h144) begin
      bad++; $display("FAIL sf_next got=%b/%h exp=0001/144", b_out_valid, b_out_data[0 +: 9]);
    end
    step();
  endtask

  task automatic test_range_err();
    c_out_ready = 3'b111;
    c_in_data = 9'h044; c_s_data = 2'd3; c_in_valid = 1'b1; c_s_valid = 1'b1;
    #1;
    total++; if ({c_in_ready, c_s_ready} !== 2'b11) begin bad++; $display("FAIL err_hs got=%b exp=11", {c_in_ready, c_s_ready}); end
    total++; if (c_err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", c_err); end
    step();
    c_in_data = 9'h0BB; c_s_data = 2'd2;
    #1;
    total++; if (c_out_valid !== 3'b000) begin bad++; $display("FAIL err_drop got=%b exp=000", c_out_valid); end
    total++; if (c_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", c_err); end
    total++; if (c_in_ready !== 1'b1) begin bad++; $display("FAIL err_next_ready got=%b exp=1", c_in_ready); end
    step();
    c_in_valid = 1'b0; c_s_valid = 1'b0;
    total++; if (c_out_valid !== 3'b100 || c_out_data[18 +: 9] !== 9'h0BB) begin
      bad++; $display("FAIL err_route got=%b/%h exp=100/0bb", c_out_valid, c_out_data[18 +: 9]);
    end
    step();
    step();
    total++; if (c_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", c_err); end
  endtask

  task automatic test_reset_mid_packet();
    b_out_ready = 4'b0000;
    b_in_data = 9'h031; b_s_data = 2'd1; b_in_valid = 1'b1; b_s_valid = 1'b1;
    step();
    b_in_data = 9'h032; b_s_valid = 1'b0;
    step();
    b_in_data = 9'h033;
    #1;
    total++; if (b_out_valid !== 4'b0010 || b_in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_buffered got=%b/%b exp=0010/0", b_out_valid, b_in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (b_out_valid !== 4'b0000) begin bad++; $display("FAIL mid_async_clear got=%b exp=0000", b_out_valid); end
    total++; if ({b_in_ready, b_s_ready} !== 2'b00) begin bad++; $display("FAIL mid_rst_ready got=%b exp=00", {b_in_ready, b_s_ready}); end
    total++; if (c_err !== 1'b0) begin bad++; $display("FAIL mid_err_clear got=%b exp=0", c_err); end
    b_in_valid = 1'b0;
    step();
    @(negedge CLK);
    rst_n = 1'b1;
    b_out_ready = 4'b1111;
    b_in_data = 9'h1E5; b_s_data = 2'd2; b_in_valid = 1'b1; b_s_valid = 1'b1;
    #1;
    total++; if (b_s_ready !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", b_s_ready); end
    step();
    b_in_valid = 1'b0; b_s_valid = 1'b0;
    total++; if (b_out_valid !== 4'b0100 || b_out_data[18 +: 9] !== 9'h1E5) begin
      bad++; $display("FAIL mid_reroute got=%b/%h exp=0100/1e5", b_out_valid, b_out_data[18 +: 9]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_packet();
    test_single_flit();
    test_range_err();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_leaf_n.md
Name: decoder_leaf_n

Overview:
- Clocked, parametrised successor of the 2-way decoder leaf.
- Routes W-bit flits from one input channel to one of N output channels. The destination is taken from a separate select channel S.
- Each output has its own DEPTH-entry FIFO, so one stalled output does not block the others beyond its own backpressure.
- Adds a packet mode: S is consumed only on the head flit, and the route stays locked until the tail flit. The output index is checked against N.
- Sits at the leaves of the NoC decoder tree, in place of the fixed 2-output, 9-bit leaf with its full buffers.

Parameters:
- W, 9, flit width in bits. Bit W-1 is the tail marker in packet mode.
- N, 4, number of output channels, N >= 2.
- DEPTH, 2, entries per output FIFO, DEPTH >= 1.
- PKT_MODE, 0, 0 = select consumed with every flit; 1 = select consumed on head flit only, route held until tail.
- SW, $clog2(N), select width (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- _RESET  in  1  asynchronous active-low reset.
- in_data  in  W  input flit.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted this cycle when high together with in_valid.
- s_data  in  SW  destination output index.
- s_valid  in  1  select valid.
- s_ready  out  1  select consumed this cycle when high together with s_valid.
- out_data  out  N*W  output flits, channel k at bits [k*W +: W].
- out_valid  out  N  per-output valid.
- out_ready  in  N  per-output ready.
- err  out  1  sticky flag: an out-of-range select was received.

Behaviour:
- Handshake: transfer on valid & ready at the rising CLK edge. Producers must not make valid depend on ready. Once raised, valid and data hold until transfer.
- Reset (asynchronous assert, synchronous release):
  - all FIFO counts 0, so out_valid = 0;
  - in_ready = 0 and s_ready = 0 while _RESET is low;
  - route FSM = IDLE, err = 0.
  - Reset mid-packet discards the locked route and all buffered flits.
- FIFOs:
  - count[k] in 0..DEPTH, circular read/write pointers wrap at DEPTH.
  - full[k] = (count[k] == DEPTH). out_valid[k] = (count[k] != 0). out_data[k] = head entry.
  - Push and pop in the same cycle leave the count unchanged. This is allowed at any count except: no push when full.
  - No same-cycle bypass: in_ready ignores out_ready.
- Latency: a flit accepted at edge t is visible on out_valid/out_data at t+1 (after edge t). Order is preserved per output.
- Route FSM, states IDLE and LOCKED (PKT_MODE=0 never leaves IDLE):
  - IDLE: tgt = s_data.
    - If tgt < N: in_ready = s_valid & ~full[tgt]; s_ready = in_valid & ~full[tgt]. Flit and select transfer together (join).
    - If tgt >= N (possible only when N is not a power of two): in_ready = s_ready = in_valid & s_valid. The flit is dropped, err is set, and the FSM stays in IDLE.
    - On a valid transfer with PKT_MODE=1 and in_data[W-1] = 0: route <= tgt, go to LOCKED.
    - A single-flit packet (tail set on head) stays in IDLE.
  - LOCKED: s_ready = 0; in_ready = ~full[route]. A flit pushes to FIFO[route]. A transfer with in_data[W-1] = 1 goes to IDLE. An S token presented while LOCKED is held off until after the tail.
- In PKT_MODE=0, bit W-1 is ordinary data.
- err clears only on reset.
- in_ready and s_ready are combinational from valid, s_data, full and FSM state. There is no path from out_ready to in_ready.

Test Plan:
- N=4, DEPTH=2, mode 0, all out_ready=1. Send flits 0x101, 0x0A5, 0x1FF with S=2,0,3 -> each appears on the matching out_valid exactly one cycle after acceptance, with data intact.
- out_ready[1]=0. Send 3 flits to S=1 -> first two accepted; third stalls with in_ready=0 and s_ready=0. Then send a flit to S=0 -> it stalls behind the in-order input. Raise out_ready[1] -> all three drain in order 1 cycle apart.
- Mode 1, N=4. Head 0x023 (tail=0) with S=3, then body 0x055, then tail 0x1AA, with a second S=1 presented throughout -> all three flits exit on out[3]; s_ready stays 0 until after the tail; next packet goes to out[1].
- Mode 1, single-flit packet 0x1C3 with S=2 -> FSM stays IDLE; the next S is consumed with the next flit.
- N=3, S=3 with flit 0x044 -> both handshakes complete, no out_valid rises, err=1 and stays 1. A following S=2 flit is routed normally.
- Mode 1: assert _RESET low asynchronously mid-packet with 2 flits buffered -> out_valid=0 immediately and FSM=IDLE. After release, a new head flit is routed by its own S.
